// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide engine with integrated HI/LO registers.
// One product or quotient bit per cycle, a sign fix-up cycle, then the HI/LO write.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic             is_div;
  logic             sign_a;
  logic             sign_b;
  logic             zero_div;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ok;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  // Signed ops work on magnitudes; the signs are reapplied in FIX.
  assign neg_a = ~op[0] & src_a[WIDTH-1];
  assign neg_b = ~op[0] & src_b[WIDTH-1];
  assign abs_a = neg_a ? -src_a : src_a;
  assign abs_b = neg_b ? -src_b : src_b;

  // Multiply: acc_hi:acc_lo is the product register, multiplier starts in acc_lo.
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});

  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mag_b};
  assign div_ok    = ~div_diff[WIDTH];

  assign prod = {acc_hi, acc_lo};

  always_comb begin
    res_hi = acc_hi;
    res_lo = acc_lo;
    if (is_div) begin
      if (zero_div) begin
        res_hi = sign_a ? -mag_a : mag_a;
        res_lo = '1;
      end else begin
        res_lo = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
        res_hi = sign_a ? -acc_hi : acc_hi;
      end
    end else begin
      {res_hi, res_lo} = (sign_a ^ sign_b) ? -prod : prod;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      is_div      <= 1'b0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      zero_div    <= 1'b0;
      mag_a       <= '0;
      mag_b       <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (mthi) hi <= wdata;
          if (mtlo) lo <= wdata;
          if (start) begin
            state    <= CALC;
            busy     <= 1'b1;
            count    <= '0;
            is_div   <= op[1];
            sign_a   <= neg_a;
            sign_b   <= neg_b;
            zero_div <= op[1] & (src_b == '0);
            mag_a    <= abs_a;
            mag_b    <= abs_b;
            acc_hi   <= '0;
            acc_lo   <= op[1] ? abs_a : abs_b;
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            count <= '0;
          end else begin
            if (is_div) begin
              acc_hi <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
            end else begin
              acc_hi <= mul_sum[WIDTH:1];
              acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
            if (count == CW'(WIDTH - 1)) begin
              state <= FIX;
              count <= '0;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            hi          <= res_hi;
            lo          <= res_lo;
            done        <= 1'b1;
            div_by_zero <= zero_div;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: directed tables and random ops at WIDTH=32 and WIDTH=8,
// compared against a plain-arithmetic HI/LO model, plus flush/move/reset/back-to-back sequences.
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, flush, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wdata;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  logic        start8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy8, done8, dz8;
  logic        zero1 = 1'b0;
  logic [7:0]  zero8 = 8'd0;

  int n_vec = 0;
  int n_err = 0;
  int dz_stray = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t tab32[8];
  vec_t tab8[6];

  always #5 clk = ~clk;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(dz), .hi(hi), .lo(lo)
  );

  hilo_muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .src_a(a8), .src_b(b8),
    .flush(zero1), .mthi(zero1), .mtlo(zero1), .wdata(zero8),
    .busy(busy8), .done(done8), .div_by_zero(dz8), .hi(hi8), .lo(lo8)
  );

  // HI/LO model from signed/unsigned 64-bit arithmetic, masked to w bits.
  function automatic void ref_model(input int w, input logic [1:0] o, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] rh,
                                    output logic [31:0] rl, output logic rdz);
    logic [63:0] mask, ua, ub, p;
    longint sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'd0, a} & mask;
    ub   = {32'd0, b} & mask;
    sa   = $signed(ua << (64 - w)) >>> (64 - w);
    sb   = $signed(ub << (64 - w)) >>> (64 - w);
    rdz  = 1'b0;
    p    = 64'd0;
    case (o)
      2'b00: p = 64'(sa * sb);
      2'b01: p = ua * ub;
      default: begin
        if (ub == 64'd0) begin
          rdz = 1'b1;
          p   = (ua << w) | mask;
        end else if (o == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          p = ((64'(r) & mask) << w) | (64'(q) & mask);
        end else begin
          p = (((ua % ub) & mask) << w) | ((ua / ub) & mask);
        end
      end
    endcase
    rh = 32'((p >> w) & mask);
    rl = 32'(p & mask);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Called just after the start edge; counts cycles until done is seen.
  task automatic wait_done32(input int c0, output int cyc, output int bc);
    cyc = c0;
    bc  = 0;
    while (!done && cyc < 200) begin
      if (busy) bc++;
      if (dz) dz_stray++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic apply_stimulus32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] rh, output logic [31:0] rl,
                                  output logic rdz, output int lat, output int bc);
    @(posedge clk); #1;
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done32(0, lat, bc);
    rh = hi; rl = lo; rdz = dz;
    check("busy_low_at_done", {63'd0, busy}, 64'd0);
  endtask

  task automatic apply_stimulus8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] rh, output logic [7:0] rl,
                                 output logic rdz, output int lat, output int bc);
    @(posedge clk); #1;
    start8 = 1'b1; op8 = o; a8 = a; b8 = b;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    bc  = 0;
    while (!done8 && lat < 100) begin
      if (busy8) bc++;
      if (dz8) dz_stray++;
      @(posedge clk); #1;
      lat++;
    end
    rh = hi8; rl = lo8; rdz = dz8;
  endtask

  task automatic check_output32(input string tag, input logic [1:0] o, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] eh,
                                input logic [31:0] el, input logic edz);
    logic [31:0] rh, rl;
    logic rdz;
    int lat, bc;
    apply_stimulus32(o, a, b, rh, rl, rdz, lat, bc);
    check({tag, "_hi"}, {32'd0, rh}, {32'd0, eh});
    check({tag, "_lo"}, {32'd0, rl}, {32'd0, el});
    check({tag, "_dz"}, {63'd0, rdz}, {63'd0, edz});
    check({tag, "_latency"}, 64'(lat), 64'd33);
    check({tag, "_busy_cycles"}, 64'(bc), 64'd33);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {62'd0, done, dz}, 64'd0);
  endtask

  task automatic check_output8(input string tag, input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] eh,
                               input logic [31:0] el, input logic edz);
    logic [7:0] rh, rl;
    logic rdz;
    int lat, bc;
    apply_stimulus8(o, a[7:0], b[7:0], rh, rl, rdz, lat, bc);
    check({tag, "_hi8"}, {56'd0, rh}, {32'd0, eh});
    check({tag, "_lo8"}, {56'd0, rl}, {32'd0, el});
    check({tag, "_dz8"}, {63'd0, rdz}, {63'd0, edz});
    check({tag, "_latency8"}, 64'(lat), 64'd9);
    check({tag, "_busy_cycles8"}, 64'(bc), 64'd9);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] eh, el, lo_prev, ra, rb;
    logic edz;
    logic [1:0] ro;
    int cyc, bc, seen;

    tab32[0] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    tab32[1] = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    tab32[2] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    tab32[3] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    tab32[4] = '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
    tab32[5] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    tab32[6] = '{2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};
    tab32[7] = '{2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};

    tab8[0] = '{2'b01, 32'hFF, 32'hFF, 32'hFE, 32'h01, 1'b0};
    tab8[1] = '{2'b00, 32'hFD, 32'h05, 32'hFF, 32'hF1, 1'b0};
    tab8[2] = '{2'b00, 32'h80, 32'h80, 32'h40, 32'h00, 1'b0};
    tab8[3] = '{2'b10, 32'hF9, 32'h02, 32'hFF, 32'hFD, 1'b0};
    tab8[4] = '{2'b10, 32'h80, 32'hFF, 32'h00, 32'h80, 1'b0};
    tab8[5] = '{2'b11, 32'h34, 32'h00, 32'h34, 32'hFF, 1'b1};

    rst = 1'b1; start = 1'b0; flush = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; src_a = '0; src_b = '0; wdata = '0;
    start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
    #12 rst = 1'b0;
    check("reset_hi_lo", {hi, lo}, 64'd0);
    check("reset_flags", {61'd0, busy, done, dz}, 64'd0);

    $display("[TB] directed table, WIDTH=32");
    for (int i = 0; i < 8; i++)
      check_output32($sformatf("tab32_%0d", i), tab32[i].op, tab32[i].a, tab32[i].b,
                     tab32[i].hi, tab32[i].lo, tab32[i].dz);

    $display("[TB] random ops vs model, WIDTH=32");
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = (i % 9 == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFFFFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      ref_model(32, ro, ra, rb, eh, el, edz);
      check_output32($sformatf("rnd32_%0d", i), ro, ra, rb, eh, el, edz);
    end

    $display("[TB] mthi then flushed mult");
    @(posedge clk); #1;
    mthi = 1'b1; wdata = 32'h0000AAAA;
    @(posedge clk); #1;
    mthi = 1'b0;
    check("mthi_hi", {32'd0, hi}, 64'h0000AAAA);
    lo_prev = lo;
    start = 1'b1; op = 2'b00; src_a = 32'd2; src_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done) seen = 1; end
    check("flush_no_done", 64'(seen), 64'd0);
    check("flush_hi_kept", {32'd0, hi}, 64'h0000AAAA);
    check("flush_lo_kept", {32'd0, lo}, {32'd0, lo_prev});

    $display("[TB] mtlo and start while busy are ignored");
    start = 1'b1; op = 2'b01; src_a = 32'd3; src_b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    mtlo = 1'b1; wdata = 32'h00005555;
    start = 1'b1; op = 2'b11; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1;
    mtlo = 1'b0; start = 1'b0;
    check("busy_mtlo_ignored", {32'd0, lo}, {32'd0, lo_prev});
    check("busy_still_high", {63'd0, busy}, 64'd1);
    wait_done32(5, cyc, bc);
    check("busy_op_latency", 64'(cyc), 64'd33);
    check("busy_op_result", {hi, lo}, 64'd12);

    $display("[TB] mthi together with start");
    @(posedge clk); #1;
    mthi = 1'b1; wdata = 32'h00001357;
    start = 1'b1; op = 2'b01; src_a = 32'd6; src_b = 32'd7;
    @(posedge clk); #1;
    mthi = 1'b0; start = 1'b0;
    check("move_with_start_hi", {32'd0, hi}, 64'h00001357);
    check("move_with_start_busy", {63'd0, busy}, 64'd1);
    wait_done32(0, cyc, bc);
    check("move_with_start_result", {hi, lo}, 64'd42);

    $display("[TB] back-to-back start on done cycle");
    @(posedge clk); #1;
    start = 1'b1; op = 2'b01; src_a = 32'd5; src_b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done32(0, cyc, bc);
    check("b2b_first_latency", 64'(cyc), 64'd33);
    check("b2b_first_result", {hi, lo}, 64'd30);
    start = 1'b1; op = 2'b11; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_second_busy", {63'd0, busy}, 64'd1);
    wait_done32(0, cyc, bc);
    check("b2b_second_latency", 64'(cyc), 64'd33);
    check("b2b_second_result", {hi, lo}, {32'd2, 32'd14});

    $display("[TB] async reset during divide");
    @(posedge clk); #1;
    start = 1'b1; op = 2'b10; src_a = 32'hFFFFFF9C; src_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check("async_rst_hi_lo", {hi, lo}, 64'd0);
    check("async_rst_flags", {61'd0, busy, done, dz}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done || busy) seen = 1; end
    check("after_rst_quiet", 64'(seen), 64'd0);

    $display("[TB] directed table and random ops, WIDTH=8");
    for (int i = 0; i < 6; i++)
      check_output8($sformatf("tab8_%0d", i), tab8[i].op, tab8[i].a, tab8[i].b,
                    tab8[i].hi, tab8[i].lo, tab8[i].dz);
    for (int i = 0; i < 20; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = 32'($urandom_range(0, 255));
      rb = (i % 5 == 0) ? 32'd0 : 32'($urandom_range(0, 255));
      ref_model(8, ro, ra, rb, eh, el, edz);
      check_output8($sformatf("rnd8_%0d", i), ro, ra, rb, eh, el, edz);
    end

    check("dz_only_with_done", 64'(dz_stray), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Parametrised iterative multiply/divide engine with integrated HI/LO registers. It is the successor to the single-cycle combinational mult/div plus HI/LO pair that sits beside the CPU core. It adds a start/busy/done handshake, a pipeline-flush abort and divide-by-zero reporting. It also generalises operand width. The CPU issues mult/multu/div/divu, mthi/mtlo and reads HI/LO through this block; the core stalls mfhi/mflo while `busy` is high.

## Interface
- `WIDTH`, default 32: operand width. HI and LO are each WIDTH bits; must be ≥ 4 and even.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin operation `op` on `src_a`/`src_b`; sampled only in IDLE.
- `op`  in  2  operation select: 00 mult (signed), 01 multu, 10 div (signed), 11 divu.
- `src_a`  in  WIDTH  multiplicand or dividend (rs).
- `src_b`  in  WIDTH  multiplier or divisor (rt).
- `flush`  in  1  abort an in-flight operation (exception/eret from CP0 path).
- `mthi`  in  1  write `wdata` to HI.
- `mtlo`  in  1  write `wdata` to LO.
- `wdata`  in  WIDTH  data for mthi/mtlo.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result.
- `div_by_zero`  out  1  valid with `done`; the completed div/divu had `src_b`==0.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States:
  - IDLE: `busy`=0.
  - CALC: iterate; a counter runs 0..WIDTH-1.
  - FIX: sign correction and HI/LO write.
- IDLE → CALC on `start`. At this edge:
  - Latch `op`.
  - Latch |src_a| and |src_b|; absolute value only for op 00/10, otherwise raw.
  - Latch the sign flags.
  - Latch a zero-divisor flag.
  - Clear the accumulator.
- CALC, multiply: shift-add, one multiplier bit per cycle, producing a 2·WIDTH-bit unsigned product.
- CALC, divide: restoring division, one quotient bit per cycle, producing a WIDTH-bit quotient and a WIDTH-bit remainder.
- CALC → FIX after WIDTH cycles. FIX → IDLE after one cycle; on that edge HI/LO are written, `done`=1 for exactly the following cycle.
- Result mapping:
  - mult/multu: HI = product[2W-1:W], LO = product[W-1:0]. For mult, the product is negated (two's complement over 2W bits) if the operand signs differ.
  - div/divu: LO = quotient, HI = remainder. For signed div, the quotient is negated if the signs differ, and the remainder takes the sign of the dividend.
  - Signed div of MIN by −1: LO = MIN, HI = 0. This falls out of the unsigned path; it is not an error.
- Divide by zero: LO = all ones, HI = src_a as originally presented (unsigned, not its absolute value). `div_by_zero`=1 together with `done`. The full WIDTH-cycle latency still applies.
- `flush` in CALC or FIX: next state IDLE, HI/LO unchanged, no `done`. `flush` in IDLE has no effect.
- mthi/mtlo are honoured only in IDLE; asserted while `busy`=1 they are ignored. mthi together with mtlo writes both.
- Simultaneous events in IDLE:
  - mthi/mtlo and `start` in the same cycle: the move is written and `start` is accepted. The later result overwrites HI/LO.
  - `start` and `flush` together: `start` is accepted.
- `start` while `busy`: ignored.

## Timing
- Reset values:
  - `hi`=0, `lo`=0
  - `busy`=0, `done`=0, `div_by_zero`=0
  - state IDLE, counter 0
- Reset asserted mid-operation aborts immediately (asynchronously) to these values.
- Start sampled at edge E0:
  - `busy`=1 from after E0 through the cycle ending at edge E0+WIDTH+1.
  - HI/LO update at edge E0+WIDTH+1; `done` is high during the following cycle, with `busy`=0.
  - Latency is WIDTH+1 cycles (33 at WIDTH=32).
- Back-to-back: a new `start` is accepted in the same cycle `done` is high.
- mthi/mtlo: HI/LO update at the next edge.
- `hi`/`lo` are registered outputs with no combinational path from inputs.
- `div_by_zero` is 0 whenever `done`=0.

## Test plan
- multu 0xFFFFFFFF × 0xFFFFFFFF (WIDTH=32) → `done` 33 cycles after start; hi=0xFFFFFFFE, lo=0x00000001; `busy` high exactly 33 cycles.
- mult −3 × 5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. mult 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- div −7 ÷ 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7 ÷ 2 → lo=3, hi=1. div 0x80000000 ÷ 0xFFFFFFFF → lo=0x80000000, hi=0.
- divu 0x1234 ÷ 0 → lo=0xFFFFFFFF, hi=0x1234, `div_by_zero`=1 for one cycle with `done`.
- Flush and mthi:
  - mthi 0xAAAA, then mult 2×3, `flush` at cycle 10 → no `done`, hi=0xAAAA.
  - mtlo 0x5555 asserted at cycle 5 of an op → ignored.
- Async `rst` at cycle 20 of a div → all outputs 0 immediately.
- Back-to-back: new `start` on the `done` cycle → second `done` 33 cycles later.
- WIDTH=8 regression: same sign and zero cases; latency 9.
